alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: DATA_W, default 12, operand/result width, signed two's complement.
REQ-002 Parameter: FRAC_W, default 5, fractional bits for MUL/MAC fixed-point rounding (1 <= FRAC_W < DATA_W).
REQ-003 Parameter: GUARD_W, default 8, extra MSBs held in the MAC accumulator.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 i_clk  input  1  clock, all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_valid  input  1  operands and instruction valid this cycle.
REQ-008 i_data_a  input  DATA_W  signed operand A.
REQ-009 i_data_b  input  DATA_W  signed operand B.
REQ-010 i_inst  input  3  opcode.
REQ-011 o_valid  output  1  result valid, one-cycle pulse per accepted op.
REQ-012 o_data  output  DATA_W  result.
REQ-013 o_overflow  output  1  result not representable in DATA_W signed; qualified by o_valid.

Function
REQ-014 Opcodes SHALL be: 000 ADD a+b; 001 SUB a-b; 010 MUL round(a*b); 011 MAC acc+round(a*b); 100 XNOR ~(a^b); 101 RELU max(a,0); 110 MAX(a,b); 111 MIN(a,b).
REQ-015 Pipeline SHALL be 2 stages: stage 1 registers a, b, inst and valid on i_valid; stage 2 computes and registers outputs; latency is exactly 2 cycles, throughput one op per cycle, no stall.
REQ-016 When i_valid=0, stage 1 SHALL capture a bubble and o_valid SHALL be 0 two cycles later; o_data and o_overflow hold their previous values during bubbles.
REQ-017 round(p) SHALL be (p + 2^(FRAC_W-1)) arithmetic-shifted right by FRAC_W on the full 2*DATA_W product (round half toward +infinity).
REQ-018 ADD/SUB/MUL SHALL be computed at full precision; o_overflow=1 iff the full-precision result lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 XNOR, RELU, MAX, MIN SHALL always report o_overflow=0.
REQ-020 MAC SHALL hold a DATA_W+GUARD_W signed accumulator; each MAC sets acc <= acc + round(a*b), the addition wrapping within DATA_W+GUARD_W bits, and outputs the new acc value.
REQ-021 MAC o_overflow SHALL be 1 iff the new acc lies outside the DATA_W signed range; the accumulator retains guard bits so later MACs can return into range.
REQ-022 Any valid non-MAC op reaching stage 2 SHALL clear the accumulator to 0 in the same cycle; bubbles SHALL NOT disturb it.
REQ-023 Back-to-back MACs on consecutive cycles SHALL each see the accumulator updated by the immediately preceding MAC.

Reset
REQ-024 On i_rst_n=0, stage-1 registers, accumulator, o_valid, o_data and o_overflow SHALL go to 0 immediately, independent of i_clk.
REQ-025 Ops in flight at reset assertion SHALL be discarded; no o_valid pulse for them after release.
REQ-026 The first op accepted after reset release SHALL produce o_valid exactly 2 cycles later.

Configuration
REQ-027 Macro ALU_PIPE_SAT_EN: when defined, overflowing ADD/SUB/MUL/MAC results SHALL drive o_data to 2^(DATA_W-1)-1 (positive) or -2^(DATA_W-1) (negative); the accumulator itself keeps the unsaturated value.
REQ-028 Without ALU_PIPE_SAT_EN, o_data SHALL be the low DATA_W bits of the result (wrap); o_overflow behaviour is identical in both builds.

Verification (DATA_W=12, FRAC_W=5, GUARD_W=8)
REQ-029 ADD a=2047, b=1 -> o_data=-2048 (wrap) or 2047 (SAT_EN), o_overflow=1, o_valid at cycle +2.
REQ-030 MUL a=64, b=48 -> 96, overflow 0; MUL a=-1, b=16 -> 0; MUL a=-1, b=17 -> -1.
REQ-031 MAC a=32, b=32 on 3 consecutive cycles -> outputs 32, 64, 96 on 3 consecutive cycles; then ADD 1+1 -> 2, next MAC 32x32 -> 32.
REQ-032 MAC a=2047, b=2047 twice -> overflow 1 both; then MAC a=-2047, b=2047 twice -> second result 0, overflow 0.
REQ-033 Ops with i_valid=1, 0, 1 alternating -> o_valid pattern 1, 0, 1 delayed 2 cycles, o_data held during the gap.
REQ-034 Assert i_rst_n=0 mid-cycle with 2 ops in flight -> outputs 0 immediately, no o_valid after release, accumulator 0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result bundle for the two-stage ALU pipeline.
//
// Handshake: valid-only, no backpressure. The producer asserts i_valid for
// one cycle per operation with i_data_a/i_data_b/i_inst stable around the
// rising clock edge; the pipeline always accepts. Exactly one o_valid pulse
// follows each accepted op two cycles later; o_data/o_overflow are only
// meaningful while o_valid=1 and otherwise hold the last result.
interface alu_pipe_if #(
   parameter int DATA_W = 12
);
   logic                     i_valid;
   logic signed [DATA_W-1:0] i_data_a;
   logic signed [DATA_W-1:0] i_data_b;
   logic [2:0]               i_inst;
   logic                     o_valid;
   logic signed [DATA_W-1:0] o_data;
   logic                     o_overflow;

   // Producer / consumer side (testbench or upstream logic)
   modport master (
      output i_valid, i_data_a, i_data_b, i_inst,
      input  o_valid, o_data, o_overflow
   );

   // ALU side
   modport slave (
      input  i_valid, i_data_a, i_data_b, i_inst,
      output o_valid, o_data, o_overflow
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage signed ALU with fixed-point MUL/MAC and a guarded
// MAC accumulator. Stage 1 registers the operands, stage 2 computes and
// registers the result. Latency 2, one op per cycle, never stalls.
//
// Optional build macro: ALU_PIPE_SAT_EN -- saturate overflowing
// ADD/SUB/MUL/MAC results on o_data instead of wrapping. The accumulator
// always keeps the unsaturated value; o_overflow is identical either way.
module alu_pipe #(
   parameter int DATA_W  = 12,
   parameter int FRAC_W  = 5,
   parameter int GUARD_W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   alu_pipe_if.slave    bus
);

   // Opcodes
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_MAC  = 3'b011;
   localparam logic [2:0] OP_XNOR = 3'b100;
   localparam logic [2:0] OP_RELU = 3'b101;
   localparam logic [2:0] OP_MAX  = 3'b110;
   localparam logic [2:0] OP_MIN  = 3'b111;

   // Widths: PW is the full product, AW the accumulator, WW a common width
   // wide enough to hold every full-precision result for range checking.
   localparam int PW = 2 * DATA_W;
   localparam int AW = DATA_W + GUARD_W;
   localparam int WW = (AW > PW + 1) ? AW : PW + 1;

   // Half an LSB of the rounded result, added before the shift so that
   // rounding goes half toward +infinity.
   localparam logic signed [PW:0] RND_HALF = (PW+1)'(2 ** (FRAC_W - 1));

   // Representable output range, in both the wide and the output width.
   localparam logic signed [WW-1:0]     WIDE_MAX = WW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [WW-1:0]     WIDE_MIN = -WIDE_MAX - WW'(1);
   localparam logic signed [DATA_W-1:0] DATA_MAX = WIDE_MAX[DATA_W-1:0];
   localparam logic signed [DATA_W-1:0] DATA_MIN = WIDE_MIN[DATA_W-1:0];

   // ---------------------------------------------------------------------
   // Stage 1: operand registers
   // ---------------------------------------------------------------------
   logic                     s1_valid;
   logic signed [DATA_W-1:0] s1_a;
   logic signed [DATA_W-1:0] s1_b;
   logic [2:0]               s1_inst;

   // Capture operands on every accepted op; a bubble only clears s1_valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_inst  <= '0;
      end else begin
         s1_valid <= bus.i_valid;
         if (bus.i_valid) begin
            s1_a    <= bus.i_data_a;
            s1_b    <= bus.i_data_b;
            s1_inst <= bus.i_inst;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: compute
   // ---------------------------------------------------------------------
   logic signed [PW-1:0]     prod;
   logic signed [PW:0]       prod_biased;
   logic signed [PW:0]       prod_rnd;
   logic signed [AW-1:0]     acc_q;
   logic signed [AW-1:0]     acc_next;
   logic signed [WW-1:0]     res_full;
   logic                     res_checked;
   logic                     res_ovf;
   logic signed [DATA_W-1:0] res_data;

   // Full-precision product and its rounded fixed-point value.
   always_comb begin
      prod        = PW'(s1_a) * PW'(s1_b);
      prod_biased = (PW+1)'(prod) + RND_HALF;
      prod_rnd    = prod_biased >>> FRAC_W;
   end

   // Per-opcode result at full precision, plus the next accumulator value.
   always_comb begin
      res_full    = '0;
      res_checked = 1'b0;
      acc_next    = acc_q;
      case (s1_inst)
         OP_ADD: begin
            res_full    = WW'(s1_a) + WW'(s1_b);
            res_checked = 1'b1;
         end
         OP_SUB: begin
            res_full    = WW'(s1_a) - WW'(s1_b);
            res_checked = 1'b1;
         end
         OP_MUL: begin
            res_full    = WW'(prod_rnd);
            res_checked = 1'b1;
         end
         OP_MAC: begin
            // Sum wraps inside the accumulator width by construction.
            acc_next    = acc_q + AW'(prod_rnd);
            res_full    = WW'(acc_next);
            res_checked = 1'b1;
         end
         OP_XNOR: res_full = WW'(~(s1_a ^ s1_b));
         OP_RELU: res_full = s1_a[DATA_W-1] ? '0 : WW'(s1_a);
         OP_MAX:  res_full = (s1_a > s1_b) ? WW'(s1_a) : WW'(s1_b);
         OP_MIN:  res_full = (s1_a < s1_b) ? WW'(s1_a) : WW'(s1_b);
         default: res_full = '0;
      endcase
      // Any non-MAC op restarts accumulation from zero.
      if (s1_inst != OP_MAC) begin
         acc_next = '0;
      end
   end

   // Range check and output formatting (wrap or saturate).
   always_comb begin
      res_ovf = res_checked && ((res_full > WIDE_MAX) || (res_full < WIDE_MIN));
`ifdef ALU_PIPE_SAT_EN
      if (res_ovf) begin
         res_data = res_full[WW-1] ? DATA_MIN : DATA_MAX;
      end else begin
         res_data = res_full[DATA_W-1:0];
      end
`else
      res_data = res_full[DATA_W-1:0];
`endif
   end

   // ---------------------------------------------------------------------
   // Stage 2: output and accumulator registers
   // ---------------------------------------------------------------------
   logic                     o_valid_q;
   logic signed [DATA_W-1:0] o_data_q;
   logic                     o_overflow_q;

   // Register results for valid ops; bubbles pulse o_valid low and leave
   // data, overflow and the accumulator untouched.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid_q    <= 1'b0;
         o_data_q     <= '0;
         o_overflow_q <= 1'b0;
         acc_q        <= '0;
      end else begin
         o_valid_q <= s1_valid;
         if (s1_valid) begin
            o_data_q     <= res_data;
            o_overflow_q <= res_ovf;
            acc_q        <= acc_next;
         end
      end
   end

   assign bus.o_valid    = o_valid_q;
   assign bus.o_data     = o_data_q;
   assign bus.o_overflow = o_overflow_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an
// integer reference model of the opcode rules.
module tb_alu_pipe;

   localparam int DATA_W  = 12;
   localparam int FRAC_W  = 5;
   localparam int GUARD_W = 8;
   localparam int EW      = DATA_W + 2;   // {valid, overflow, data}

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_pipe_if #(.DATA_W(DATA_W)) bus ();

   alu_pipe #(
      .DATA_W  (DATA_W),
      .FRAC_W  (FRAC_W),
      .GUARD_W (GUARD_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // ------------------------------------------------------------------
   // Scoreboard state
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [EW-1:0] exp_q[$];

   // Reference model state
   longint m_acc    = 0;
   longint m_last_d = 0;
   logic   m_last_o = 1'b0;

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Signed value of v modulo 2^bits.
   function automatic longint wrap(input longint v, input int bits);
      longint m, r;
      m = longint'(1) << bits;
      r = v % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   // round(p) = floor((p + half) / 2^FRAC_W)
   function automatic longint rnd(input longint p);
      longint q, d, r;
      d = longint'(1) << FRAC_W;
      q = p + d / 2;
      r = q / d;
      if (q < 0 && (q % d) != 0) r -= 1;
      return r;
   endfunction

   // Compute the expected output for one driven cycle and queue it.
   task automatic model_push(input logic v, input int a, input int b,
                             input logic [2:0] op);
      longint res, lo, hi;
      logic   chk, ovf;
      lo = -(longint'(1) << (DATA_W - 1));
      hi = (longint'(1) << (DATA_W - 1)) - 1;
      if (v) begin
         chk = 1'b1;
         case (op)
            3'd0: res = longint'(a) + b;
            3'd1: res = longint'(a) - b;
            3'd2: res = rnd(longint'(a) * b);
            3'd3: begin
               m_acc = wrap(m_acc + rnd(longint'(a) * b), DATA_W + GUARD_W);
               res = m_acc;
            end
            3'd4: begin res = wrap(~(longint'(a) ^ longint'(b)), DATA_W); chk = 1'b0; end
            3'd5: begin res = (a > 0) ? a : 0; chk = 1'b0; end
            3'd6: begin res = (a > b) ? a : b; chk = 1'b0; end
            default: begin res = (a < b) ? a : b; chk = 1'b0; end
         endcase
         if (op != 3'd3) m_acc = 0;
         ovf = chk && (res > hi || res < lo);
`ifdef ALU_PIPE_SAT_EN
         m_last_d = ovf ? ((res > 0) ? hi : lo) : wrap(res, DATA_W);
`else
         m_last_d = wrap(res, DATA_W);
`endif
         m_last_o = ovf;
      end
      exp_q.push_back({v, m_last_o, DATA_W'(m_last_d)});
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_acc    = 0;
      m_last_d = 0;
      m_last_o = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   task automatic drive(input logic v, input int a, input int b,
                        input logic [2:0] op);
      @(negedge clk);
      bus.i_valid  = v;
      bus.i_data_a = DATA_W'(a);
      bus.i_data_b = DATA_W'(b);
      bus.i_inst   = op;
      model_push(v, a, b, op);
   endtask

   // Advance one edge; once two entries are pending, the oldest is due.
   task automatic tick(input string name);
      logic [EW-1:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         check({name, ".valid"}, DATA_W'(bus.o_valid), DATA_W'(e[EW-1]));
         check({name, ".ovf"}, DATA_W'(bus.o_overflow), DATA_W'(e[EW-2]));
         check({name, ".data"}, bus.o_data, e[DATA_W-1:0]);
      end
   endtask

   task automatic step(input string name, input logic v, input int a,
                       input int b, input logic [2:0] op);
      drive(v, a, b, op);
      tick(name);
   endtask

   task automatic flush(input string name);
      step(name, 1'b0, 0, 0, 3'd0);
      step(name, 1'b0, 0, 0, 3'd0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      bus.i_valid  = 1'b0;
      bus.i_data_a = '0;
      bus.i_data_b = '0;
      bus.i_inst   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.valid", DATA_W'(bus.o_valid), '0);
      check("rst.ovf", DATA_W'(bus.o_overflow), '0);
      check("rst.data", bus.o_data, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD overflow at the positive edge of the range
      step("add_ovf", 1'b1, 2047, 1, 3'd0);
      flush("add_ovf");

      // MUL rounding cases
      step("mul_a", 1'b1, 64, 48, 3'd2);
      step("mul_b", 1'b1, -1, 16, 3'd2);
      step("mul_c", 1'b1, -1, 17, 3'd2);
      flush("mul");

      // Back-to-back MACs, clear by ADD, restart
      step("mac_run", 1'b1, 32, 32, 3'd3);
      step("mac_run", 1'b1, 32, 32, 3'd3);
      step("mac_run", 1'b1, 32, 32, 3'd3);
      step("mac_clr", 1'b1, 1, 1, 3'd0);
      step("mac_new", 1'b1, 32, 32, 3'd3);
      flush("mac");

      // Guard bits let the accumulator return into range
      step("mac_grd", 1'b1, 0, 0, 3'd0);
      step("mac_grd", 1'b1, 2047, 2047, 3'd3);
      step("mac_grd", 1'b1, 2047, 2047, 3'd3);
      step("mac_grd", 1'b1, -2047, 2047, 3'd3);
      step("mac_grd", 1'b1, -2047, 2047, 3'd3);
      flush("mac_grd");

      // Valid / bubble / valid; bubble between MACs must not clear acc
      step("gap", 1'b1, 100, -30, 3'd1);
      step("gap", 1'b0, 5, 5, 3'd0);
      step("gap", 1'b1, -7, 9, 3'd6);
      step("gap", 1'b1, 64, 64, 3'd3);
      step("gap", 1'b0, 0, 0, 3'd0);
      step("gap", 1'b1, 64, 64, 3'd3);
      flush("gap");

      // Reset mid-cycle with ops in flight
      step("pre_rst", 1'b1, 32, 32, 3'd3);
      step("pre_rst", 1'b1, 32, 32, 3'd3);
      drive(1'b1, 3, 4, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.valid", DATA_W'(bus.o_valid), '0);
      check("midrst.ovf", DATA_W'(bus.o_overflow), '0);
      check("midrst.data", bus.o_data, '0);
      model_reset();
      @(negedge clk);
      bus.i_valid = 1'b0;
      rst_n = 1'b1;
      step("post_rst", 1'b0, 0, 0, 3'd0);
      step("post_rst", 1'b0, 0, 0, 3'd0);
      step("post_rst", 1'b0, 0, 0, 3'd0);
      step("post_rst", 1'b1, 32, 32, 3'd3);
      flush("post_rst");

      // Randomized traffic; small operands sometimes so MAC chains stay
      // near the range boundary.
      for (int i = 0; i < 400; i++) begin
         logic       v;
         logic [2:0] op;
         int         a, b;
         v  = ($urandom_range(0, 3) != 0);
         op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            a = int'($urandom_range(0, 4095)) - 2048;
            b = int'($urandom_range(0, 4095)) - 2048;
         end else begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
         end
         if ($urandom_range(0, 2) == 0) op = 3'd3;
         step("rand", v, a, b, op);
      end
      flush("rand");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
